// File: rtl/uart_fifo_pkg.sv
// Shared encodings and width defaults for the UART FIFO drain path.
package uart_fifo_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int CNT_W_DEFAULT  = 9;

  // One-hot so each state decode is a single flop bit.
  typedef enum logic [4:0] {
    IDLE    = 5'b00001,
    RD      = 5'b00010,
    WAIT_RD = 5'b00100,
    START   = 5'b01000,
    WAIT_TX = 5'b10000
  } sched_state_e;

endpackage

// File: rtl/sched_timeout_cnt.sv
// Saturating cycle counter; hit_o stays high once TIMEOUT increments have accumulated.
module sched_timeout_cnt #(
  parameter int TIMEOUT = 1000,
  parameter int TO_W    = 16
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic hit_o
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_o = (cnt_q == LIMIT);

endmodule

// File: rtl/fifo_tx_scheduler.sv
// Burst scheduler draining the TX FIFO into the UART, one byte per frame,
// started by a fill threshold or by a timeout on a partially filled FIFO.
module fifo_tx_scheduler
  import uart_fifo_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int START_LEVEL = 16,
  parameter int TIMEOUT     = 1000,
  parameter int TO_W        = 16,
  parameter int RD_LATENCY  = 1
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [CNT_W-1:0]  fifo_data_count,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              fifo_rd_en,
  input  logic              uart_tx_done,
  output logic              uart_tx_start,
  output logic [DATA_W-1:0] uart_tx_data,
  output logic              burst_active,
  output logic [15:0]       tx_count
);

  // A zero level would never be "reached" by a non-empty FIFO in a useful way; treat it as 1.
  localparam int               LEVEL_EFF = (START_LEVEL < 1) ? 1 : START_LEVEL;
  localparam logic [CNT_W-1:0] LEVEL_C   = CNT_W'(LEVEL_EFF);
  localparam logic [1:0]       LAT_LAST  = 2'(RD_LATENCY - 1);

  sched_state_e      state_q, state_d;
  logic [1:0]        lat_q, lat_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic              to_clr, to_inc, to_hit, go;

  sched_timeout_cnt #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk_i  (sys_clk),
    .srst_i (sys_rst),
    .clr_i  (to_clr),
    .inc_i  (to_inc),
    .hit_o  (to_hit)
  );

  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    data_d        = data_q;
    tx_count_d    = tx_count_q;
    to_clr        = 1'b1;
    to_inc        = 1'b0;
    fifo_rd_en    = 1'b0;
    uart_tx_start = 1'b0;
    go            = enable && !fifo_empty && ((fifo_data_count >= LEVEL_C) || to_hit);

    unique case (state_q)
      IDLE: begin
        to_clr = fifo_empty || !enable || go;
        to_inc = !to_clr;
        if (go) begin
          state_d = RD;
        end
      end
      RD: begin
        fifo_rd_en = 1'b1;
        lat_d      = '0;
        state_d    = WAIT_RD;
      end
      WAIT_RD: begin
        if (lat_q == LAT_LAST) begin
          data_d  = fifo_rd_data;
          state_d = START;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      START: begin
        uart_tx_start = 1'b1;
        state_d       = WAIT_TX;
      end
      WAIT_TX: begin
        // Done is only honoured here, so a done coincident with the start pulse is dropped.
        if (uart_tx_done) begin
          tx_count_d = tx_count_q + 16'd1;
          state_d    = (enable && !fifo_empty) ? RD : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      lat_q      <= '0;
      data_q     <= '0;
      tx_count_q <= '0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      data_q     <= data_d;
      tx_count_q <= tx_count_d;
    end
  end

  assign burst_active = (state_q != IDLE);
  assign uart_tx_data = data_q;
  assign tx_count     = tx_count_q;

endmodule
